// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its execute stage, plus the
// single-cycle ALU and the divider operand/sign helpers.
package instr_register_pkg;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef logic signed [31:0] operand_t;
  typedef logic        [4:0]  address_t;
  typedef logic signed [63:0] result_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_DIVIDE,
    S_OUTPUT,
    S_FINISH
  } exec_state_t;

  function automatic logic is_div_op(input opcode_t opc);
    return (opc == DIV) || (opc == MOD);
  endfunction

  // Operands are sign-extended before the op, so ADD/SUB/MULT cannot overflow.
  // Divide ops return 0 here; they go through the serial divider instead.
  function automatic result_t alu(input instruction_t ins);
    result_t a;
    result_t b;
    a = result_t'(ins.op_a);
    b = result_t'(ins.op_b);
    case (ins.opc)
      PASSA:   return a;
      PASSB:   return b;
      ADD:     return a + b;
      SUB:     return a - b;
      MULT:    return a * b;
      default: return '0;
    endcase
  endfunction

  // Magnitude as unsigned; -2^31 maps cleanly to 2^31.
  function automatic logic [31:0] magnitude(input operand_t v);
    return v[31] ? 32'(-v) : 32'(v);
  endfunction

  function automatic result_t apply_sign(input logic neg, input logic [31:0] mag);
    result_t ext;
    ext = result_t'({32'd0, mag});
    return neg ? -ext : ext;
  endfunction

endpackage

// File: rtl/serial_divider.sv
// Unsigned restoring divider: one quotient bit per cycle for W cycles after
// start_i, then a one-cycle done_o pulse with quotient and remainder.
module serial_divider #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_i,
  input  logic [W-1:0] dividend_i,
  input  logic [W-1:0] divisor_i,
  output logic         done_o,
  output logic [W-1:0] quotient_o,
  output logic [W-1:0] remainder_o
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  quo_q, rem_q, dvs_q;
  logic [CW-1:0] cnt_q;
  logic          done_q;
  logic [W:0]    shifted_d;
  logic          take_d;

  // Partial remainder stays below the divisor, so the shift fits in W+1 bits.
  assign shifted_d = {rem_q, quo_q[W-1]};
  assign take_d    = shifted_d >= {1'b0, dvs_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        quo_q <= dividend_i;
        rem_q <= '0;
        dvs_q <= divisor_i;
        cnt_q <= CW'(W);
      end else if (cnt_q != '0) begin
        quo_q <= {quo_q[W-2:0], take_d};
        rem_q <= take_d ? W'(shifted_d - {1'b0, dvs_q}) : shifted_d[W-1:0];
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) done_q <= 1'b1;
      end
    end
  end

  assign done_o      = done_q;
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/instr_exec_unit.sv
// Execute stage: walks a contiguous (wrapping) range of the instruction
// register and hands out one result per instruction over valid/ready.
module instr_exec_unit
  import instr_register_pkg::*;
#(
  parameter int NUM_ENTRIES = 32,
  parameter int DIV_ITER    = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  address_t     first_addr,
  input  logic [5:0]   num_instr,
  output address_t     read_pointer,
  input  instruction_t instruction_word,
  output logic         res_valid,
  input  logic         res_ready,
  output result_t      res_value,
  output opcode_t      res_opcode,
  output address_t     res_addr,
  output logic         div_zero,
  output logic         busy,
  output logic         done
);

  exec_state_t  state_q;
  instruction_t instr_q;
  address_t     rp_q, res_addr_q;
  logic [5:0]   remaining_q;
  result_t      res_value_q;
  opcode_t      res_opcode_q;
  logic         res_valid_q, div_zero_q, busy_q, done_q;

  logic          div_start_d, div_done;
  logic [31:0]   div_quo, div_rem;
  result_t       div_result_d;
  address_t      rp_next_d;

  assign div_start_d = (state_q == S_EXEC) && is_div_op(instr_q.opc) && (instr_q.op_b != '0);

  serial_divider #(.W(DIV_ITER)) u_div (
    .clk         (clk),
    .reset       (reset),
    .start_i     (div_start_d),
    .dividend_i  (magnitude(instr_q.op_a)),
    .divisor_i   (magnitude(instr_q.op_b)),
    .done_o      (div_done),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

  // Sign fix: quotient truncates toward zero, remainder follows op_a.
  assign div_result_d = (instr_q.opc == DIV)
                      ? apply_sign(instr_q.op_a[31] ^ instr_q.op_b[31], div_quo)
                      : apply_sign(instr_q.op_a[31], div_rem);

  assign rp_next_d = (rp_q == address_t'(NUM_ENTRIES - 1)) ? '0 : rp_q + address_t'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      instr_q      <= '0;
      rp_q         <= '0;
      res_addr_q   <= '0;
      remaining_q  <= '0;
      res_value_q  <= '0;
      res_opcode_q <= ZERO;
      res_valid_q  <= 1'b0;
      div_zero_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (num_instr == '0) begin
              state_q <= S_FINISH;
            end else begin
              rp_q        <= first_addr;
              remaining_q <= num_instr;
              state_q     <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          instr_q      <= instruction_word;
          res_addr_q   <= rp_q;
          res_opcode_q <= instruction_word.opc;
          state_q      <= S_EXEC;
        end
        S_EXEC: begin
          if (!is_div_op(instr_q.opc)) begin
            res_value_q <= alu(instr_q);
            res_valid_q <= 1'b1;
            state_q     <= S_OUTPUT;
          end else if (instr_q.op_b == '0) begin
            res_value_q <= '0;
            div_zero_q  <= 1'b1;
            res_valid_q <= 1'b1;
            state_q     <= S_OUTPUT;
          end else begin
            state_q <= S_DIVIDE;
          end
        end
        S_DIVIDE: begin
          if (div_done) begin
            res_value_q <= div_result_d;
            res_valid_q <= 1'b1;
            state_q     <= S_OUTPUT;
          end
        end
        S_OUTPUT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            div_zero_q  <= 1'b0;
            remaining_q <= remaining_q - 6'd1;
            rp_q        <= rp_next_d;
            state_q     <= (remaining_q == 6'd1) ? S_FINISH : S_FETCH;
          end
        end
        S_FINISH: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign read_pointer = rp_q;
  assign res_valid    = res_valid_q;
  assign res_value    = res_value_q;
  assign res_opcode   = res_opcode_q;
  assign res_addr     = res_addr_q;
  assign div_zero     = div_zero_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: doc/instr_exec_unit.md
Name: instr_exec_unit

Overview:
- Execute stage directly downstream of the instruction register.
- On a start command, drives read_pointer over a contiguous range of register entries, wrapping modulo 32.
- Samples each instruction_word, computes the operation, and presents one result per instruction over a valid/ready handshake.
- Runs the testbench-visible flow "load N instructions, then execute N".

Parameters:
- NUM_ENTRIES, 32, register depth; read_pointer wraps modulo NUM_ENTRIES. Must equal 2**$bits(address_t).
- DIV_ITER, 32, divider iterations; equals operand width.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle command pulse; ignored unless busy=0.
- first_addr  in  address_t(5)  first register entry to execute.
- num_instr  in  6  instruction count, 0..32.
- read_pointer  out  address_t(5)  address to the instruction register, whose read is combinational.
- instruction_word  in  instruction_t  {opc, op_a, op_b} at read_pointer.
- res_valid  out  1  result available.
- res_ready  in  1  downstream accepts the result.
- res_value  out  result_t(64)  signed result.
- res_opcode  out  opcode_t  opcode of the result.
- res_addr  out  address_t  entry the result came from.
- div_zero  out  1  qualifies res_valid; DIV/MOD with op_b=0.
- busy  out  1  not IDLE.
- done  out  1  one-cycle pulse after the last result is accepted.

Behaviour:
- Reset values: all outputs 0; state IDLE; internal count 0. Reset wins over every other input, including mid-divide and mid-handshake. The pending result is dropped and no done pulse is issued.
- States: IDLE, FETCH, EXEC, DIVIDE, OUTPUT, FINISH.
- IDLE, start=1 (edge N):
  - num_instr=0 -> FINISH (done high after edge N+1).
  - otherwise -> read_pointer<=first_addr, remaining<=num_instr, go to FETCH.
- FETCH: latch instruction_word and res_addr<=read_pointer; go to EXEC.
- EXEC, single-cycle ops: compute res_value, assert res_valid, go to OUTPUT. For a non-divide op, res_valid is first high after edge N+2.
- EXEC, DIV/MOD with op_b!=0: start the divider; go to DIVIDE.
- EXEC, DIV/MOD with op_b==0: res_value=0, div_zero=1, res_valid=1; go to OUTPUT with no divider cycles.
- DIVIDE: wait for divider done (DIV_ITER+1 cycles), load the result, set res_valid, go to OUTPUT.
- OUTPUT:
  - res_value, res_opcode, res_addr and div_zero stay stable while res_valid=1 and res_ready=0.
  - On res_valid&&res_ready: clear res_valid and div_zero, remaining--, read_pointer++ (5-bit wrap, 31->0).
  - If remaining was 1 -> FINISH; else -> FETCH.
  - res_ready may already be high when res_valid rises; acceptance then happens on that first edge.
- FINISH: done=1 for exactly one cycle, busy=0 next cycle; return to IDLE.
- start while busy=1: ignored, no side effects.
- Arithmetic (operands signed 32-bit, result signed 64-bit, sign-extended):
  - ZERO -> 0.
  - PASSA -> op_a.
  - PASSB -> op_b.
  - ADD -> op_a+op_b, no overflow.
  - SUB -> op_a-op_b.
  - MULT -> full 64-bit signed product.
  - DIV -> quotient, truncated toward zero.
  - MOD -> remainder, sign of op_a.
  - Quotient for -2^31 / -1 = +2^31; no overflow at 64 bits.
- Illegal or unused opcode encodings produce 0.

Decomposition:
- instr_register_pkg (shared), which is the home of:
  - opcode_t: 4-bit enum ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD.
  - operand_t: signed 32.
  - address_t: 5.
  - instruction_t: struct {opc, op_a, op_b}.
  - New additions: result_t (signed 64) and exec_state_t.
- tb_ifc gains res_* signals, res_ready, start, first_addr, num_instr, busy and done in its clocking block.
- Sub-module serial_divider:
  - Unsigned restoring divider with start/done.
  - One quotient bit per cycle over DIV_ITER cycles, plus one cycle for the sign fix applied in the wrapper.

Test Plan:
1. Load entry0={ADD,5,-7}; start first_addr=0 num_instr=1, res_ready=1 -> res_valid after edge N+2, res_value=-2, res_addr=0; done on the next cycle.
2. Entries 30,31,0 = {MULT,-3,40000}, {SUB,0,1}, {PASSB,0,9}; first_addr=30, num_instr=3 -> results -120000, -1, 9 with res_addr 30, 31, 0 (wrap).
3. {DIV,-7,2} then {MOD,-7,2} -> -3 after 33 DIVIDE cycles, then -1; {DIV,8,0} -> res_value 0, div_zero=1, no DIVIDE cycles.
4. res_ready held 0 for 5 cycles on {PASSA,123,0} -> outputs stable at 123 throughout; a start pulse during the stall is ignored; done follows acceptance.
5. reset=1 during DIVIDE of {DIV,100,3} -> next cycle all outputs 0 and state IDLE; a new start with num_instr=1 on {ZERO,4,4} returns 0.
6. start with num_instr=0 -> no res_valid; done high one cycle later; read_pointer stays 0.
